// File: rtl/sr_latch_write_driver.sv
// Write driver for a bank of cross-coupled NAND SR latches: strobes a captured word,
// waits for the latches to settle, reads them back and retries on mismatch.
module sr_latch_write_driver #(
  parameter int WIDTH         = 8,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] s_n,
  output logic [WIDTH-1:0] r_n,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0]       PULSE_LAST  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRY);
  localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_retry;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_s_n;
  logic [WIDTH-1:0] r_r_n;
  logic             r_wr_ready;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_rd_data;

  state_t           w_state;
  logic [3:0]       w_cnt;
  logic [2:0]       w_retry;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_s_n;
  logic [WIDTH-1:0] w_r_n;
  logic             w_wr_ready;
  logic             w_done;
  logic             w_err;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_mismatch;

  assign w_mismatch = (q_fb != r_data);

  // Next-state and next-output logic; strobes default inactive so only PULSE drives them.
  // s_n and r_n are always complementary while active, so a latch never sees both low.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_retry    = r_retry;
    w_data     = r_data;
    w_s_n      = ALL_ONES;
    w_r_n      = ALL_ONES;
    w_wr_ready = 1'b0;
    w_done     = 1'b0;
    w_err      = r_err;
    w_rd_data  = r_rd_data;
    case (r_state)
      ST_IDLE: begin
        if (wr_valid && r_wr_ready) begin
          w_data  = wr_data;
          w_retry = 3'd0;
          w_cnt   = 4'd0;
          w_s_n   = ~wr_data;
          w_r_n   = wr_data;
          w_state = ST_PULSE;
        end else begin
          w_wr_ready = 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_cnt = 4'd0;
          if (SETTLE_CYCLES == 0) begin
            w_state = ST_CHECK;
          end else begin
            w_state = ST_SETTLE;
          end
        end else begin
          w_cnt = r_cnt + 4'd1;
          w_s_n = ~r_data;
          w_r_n = r_data;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt   = 4'd0;
          w_state = ST_CHECK;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      ST_CHECK: begin
        if (!w_mismatch || (r_retry == RETRY_LIMIT)) begin
          w_done    = 1'b1;
          w_err     = w_mismatch;
          w_rd_data = q_fb;
          w_state   = ST_DONE;
        end else begin
          w_retry = r_retry + 3'd1;
          w_s_n   = ~r_data;
          w_r_n   = r_data;
          w_state = ST_PULSE;
        end
      end
      ST_DONE: begin
        w_wr_ready = 1'b1;
        w_state    = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset forces strobes inactive without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_retry    <= 3'd0;
      r_data     <= {WIDTH{1'b0}};
      r_s_n      <= ALL_ONES;
      r_r_n      <= ALL_ONES;
      r_wr_ready <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= {WIDTH{1'b0}};
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_retry    <= w_retry;
      r_data     <= w_data;
      r_s_n      <= w_s_n;
      r_r_n      <= w_r_n;
      r_wr_ready <= w_wr_ready;
      r_done     <= w_done;
      r_err      <= w_err;
      r_rd_data  <= w_rd_data;
    end
  end

  assign wr_ready = r_wr_ready;
  assign s_n      = r_s_n;
  assign r_n      = r_r_n;
  assign done     = r_done;
  assign err      = r_err;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_sr_latch_write_driver.sv
// Bench for sr_latch_write_driver: two instances (default timing and a 1-cycle pulse, no settle)
// driven against a behavioural SR latch bank with injectable readback faults.
module tb_sr_latch_write_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       wr_valid_d, wr_ready_d, done_d, err_d;
  logic [7:0] s_n_d, r_n_d, q_fb_d, rd_d;
  logic       wr_valid_f, wr_ready_f, done_f, err_f;
  logic [7:0] s_n_f, r_n_f, q_fb_f, rd_f;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  // readback fault injection: attempts numbered below good_from read back bad_val
  int         good_from = 0;
  logic [7:0] bad_val = 8'h00;
  int         phase_base = 0;
  int         phase_d = 0, phase_f = 0;
  logic       pact_d = 1'b0, pact_f = 1'b0;
  int         overlap_cnt = 0;
  logic [7:0] lq_d = 8'h00, lq_f = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign wr_valid_d = wr_valid & ~sel;
  assign wr_valid_f = wr_valid & sel;

  wire act_d = ((s_n_d & r_n_d) != 8'hFF);
  wire act_f = ((s_n_f & r_n_f) != 8'hFF);

  assign q_fb_d = (!sel && ((phase_d - phase_base) < good_from)) ? bad_val : lq_d;
  assign q_fb_f = (sel && ((phase_f - phase_base) < good_from)) ? bad_val : lq_f;

  wire [7:0] s_n_m   = sel ? s_n_f : s_n_d;
  wire [7:0] r_n_m   = sel ? r_n_f : r_n_d;
  wire       ready_m = sel ? wr_ready_f : wr_ready_d;
  wire       done_m  = sel ? done_f : done_d;
  wire       err_m   = sel ? err_f : err_d;
  wire [7:0] rd_m    = sel ? rd_f : rd_d;
  wire       act_m   = sel ? act_f : act_d;

  sr_latch_write_driver #(.WIDTH(8), .PULSE_CYCLES(2), .SETTLE_CYCLES(1), .MAX_RETRY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_d), .wr_ready(wr_ready_d), .wr_data(wr_data),
    .s_n(s_n_d), .r_n(r_n_d), .q_fb(q_fb_d), .done(done_d), .err(err_d), .rd_data(rd_d));

  sr_latch_write_driver #(.WIDTH(8), .PULSE_CYCLES(1), .SETTLE_CYCLES(0), .MAX_RETRY(2)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid_f), .wr_ready(wr_ready_f), .wr_data(wr_data),
    .s_n(s_n_f), .r_n(r_n_f), .q_fb(q_fb_f), .done(done_f), .err(err_f), .rd_data(rd_f));

  // NAND latch bank: a low set forces 1, a low reset forces 0, otherwise hold
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!s_n_d[i]) lq_d[i] <= 1'b1;
      else if (!r_n_d[i]) lq_d[i] <= 1'b0;
      if (!s_n_f[i]) lq_f[i] <= 1'b1;
      else if (!r_n_f[i]) lq_f[i] <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (act_d && !pact_d) phase_d <= phase_d + 1;
    if (act_f && !pact_f) phase_f <= phase_f + 1;
    pact_d <= act_d;
    pact_f <= act_f;
    if (((~s_n_d & ~r_n_d) != 8'h00) || ((~s_n_f & ~r_n_f) != 8'h00)) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic run_write(input logic [7:0] data, input int gf, input logic [7:0] bd, input string tag);
    int p, s, attempts, lat, e0, done_edge, ndone, act_cycles, bad_strobe, w;
    logic [7:0] qk, got_rd;
    logic got_err;
    p = sel ? 1 : 2;
    s = sel ? 0 : 1;
    attempts = 0;
    qk = data;
    for (int k = 1; k <= 3; k++) begin
      attempts = k;
      qk = (k < gf) ? bd : data;
      if (qk == data) break;
    end
    lat = attempts * (p + s + 1);
    good_from = gf;
    bad_val = bd;
    @(negedge clk);
    phase_base = sel ? phase_f : phase_d;
    wr_data = data;
    wr_valid = 1'b1;
    w = 0;
    while (!ready_m && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (ready_m !== 1'b1) $display("FAIL %s ready_wait: wr_ready=%b required 1", tag, ready_m);
    else n_pass++;
    e0 = cyc + 1;
    @(negedge clk);
    wr_valid = 1'b0;
    done_edge = -1; ndone = 0; act_cycles = 0; bad_strobe = 0;
    got_rd = 8'h00; got_err = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (act_m) begin
        act_cycles++;
        if (s_n_m !== ~data || r_n_m !== data) bad_strobe++;
      end
      if (done_m) begin
        ndone++;
        if (done_edge < 0) begin
          done_edge = cyc;
          got_rd = rd_m;
          got_err = err_m;
        end
      end
      if (done_edge >= 0 && cyc >= done_edge + 1) break;
      @(negedge clk);
    end
    n_total++;
    if (done_edge - e0 !== lat) $display("FAIL %s done_latency: got %0d required %0d", tag, done_edge - e0, lat);
    else n_pass++;
    n_total++;
    if (got_err !== (qk != data)) $display("FAIL %s err: got %b required %b", tag, got_err, (qk != data));
    else n_pass++;
    n_total++;
    if (got_rd !== qk) $display("FAIL %s rd_data: got %h required %h", tag, got_rd, qk);
    else n_pass++;
    n_total++;
    if (act_cycles !== p * attempts) $display("FAIL %s strobe_cycles: got %0d required %0d", tag, act_cycles, p * attempts);
    else n_pass++;
    n_total++;
    if (bad_strobe !== 0) $display("FAIL %s strobe_pattern: %0d wrong cycles required 0", tag, bad_strobe);
    else n_pass++;
    n_total++;
    if (ndone !== 1) $display("FAIL %s done_count: got %0d required 1", tag, ndone);
    else n_pass++;
    n_total++;
    if (done_m !== 1'b0 || ready_m !== 1'b1 || rd_m !== qk)
      $display("FAIL %s after_done: done=%b wr_ready=%b rd_data=%h required 0 1 %h", tag, done_m, ready_m, rd_m, qk);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (s_n_d !== 8'hFF || r_n_d !== 8'hFF || wr_ready_d !== 1'b0 || done_d !== 1'b0 || err_d !== 1'b0 || rd_d !== 8'h00)
      $display("FAIL reset_state: s_n=%h r_n=%h rdy=%b done=%b err=%b rd=%h required FF FF 0 0 0 00",
               s_n_d, r_n_d, wr_ready_d, done_d, err_d, rd_d);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (wr_ready_d !== 1'b1 || wr_ready_f !== 1'b1) $display("FAIL reset_release_ready: got %b/%b required 1/1", wr_ready_d, wr_ready_f);
    else n_pass++;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_write(8'hA5, 0, 8'h00, "basic_A5");
  endtask

  task automatic test_extremes();
    sel = 1'b0;
    run_write(8'h00, 0, 8'h00, "all_zero");
    run_write(8'hFF, 0, 8'h00, "all_one");
  endtask

  task automatic test_retry();
    sel = 1'b0;
    run_write(8'hF0, 100, 8'h0F, "stuck_0F");
    run_write(8'h3C, 2, 8'h00, "retry_once");
    sel = 1'b1;
    run_write(8'h5A, 100, 8'h12, "fast_stuck");
  endtask

  task automatic test_random();
    logic [7:0] d, bd;
    int mode, gf;
    for (int n = 0; n < 16; n++) begin
      sel = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      mode = $urandom_range(0, 3);
      gf = (mode == 0) ? 0 : (mode == 1) ? 2 : (mode == 2) ? 3 : 100;
      bd = (mode == 3 && $urandom_range(0, 3) == 0) ? d : d ^ 8'($urandom_range(1, 255));
      run_write(d, gf, bd, "random");
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    good_from = 0;
    @(negedge clk);
    wr_data = 8'h5A;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (s_n_d !== 8'hA5 || r_n_d !== 8'h5A) $display("FAIL midreset_pulse2: s_n=%h r_n=%h required A5 5A", s_n_d, r_n_d);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (s_n_d !== 8'hFF || r_n_d !== 8'hFF) $display("FAIL midreset_strobes: s_n=%h r_n=%h required FF FF", s_n_d, r_n_d);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      n_total++;
      if (done_d !== 1'b0) $display("FAIL midreset_no_done: done=%b required 0", done_d);
      else n_pass++;
    end
    n_total++;
    if (wr_ready_d !== 1'b1 || s_n_d !== 8'hFF || r_n_d !== 8'hFF)
      $display("FAIL midreset_idle: rdy=%b s_n=%h r_n=%h required 1 FF FF", wr_ready_d, s_n_d, r_n_d);
    else n_pass++;
    run_write(8'h11, 0, 8'h00, "after_reset_11");
  endtask

  task automatic test_back_to_back();
    int e0, done_edge;
    sel = 1'b1;
    good_from = 0;
    @(negedge clk);
    wr_data = 8'h81;
    wr_valid = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    wr_data = 8'h7E;
    done_edge = -1;
    for (int t = 0; t < 20 && done_edge < 0; t++) begin
      if (done_f) done_edge = cyc;
      else @(negedge clk);
    end
    n_total++;
    if (done_edge - e0 !== 2 || rd_f !== 8'h81 || err_f !== 1'b0)
      $display("FAIL b2b_first: latency=%0d rd=%h err=%b required 2 81 0", done_edge - e0, rd_f, err_f);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (wr_ready_f !== 1'b1 || act_f !== 1'b0) $display("FAIL b2b_idle_gap: rdy=%b active=%b required 1 0", wr_ready_f, act_f);
    else n_pass++;
    @(negedge clk);
    wr_valid = 1'b0;
    n_total++;
    if (wr_ready_f !== 1'b0 || s_n_f !== 8'h81 || r_n_f !== 8'h7E)
      $display("FAIL b2b_second_accept: rdy=%b s_n=%h r_n=%h required 0 81 7E", wr_ready_f, s_n_f, r_n_f);
    else n_pass++;
    done_edge = -1;
    for (int t = 0; t < 20 && done_edge < 0; t++) begin
      @(negedge clk);
      if (done_f) done_edge = cyc;
    end
    n_total++;
    if (done_edge < 0 || rd_f !== 8'h7E || err_f !== 1'b0) $display("FAIL b2b_second_done: edge=%0d rd=%h err=%b required 7E 0", done_edge, rd_f, err_f);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_overlap();
    n_total++;
    if (overlap_cnt !== 0) $display("FAIL strobe_overlap: %0d cycles with both strobes low required 0", overlap_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_retry();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_no_overlap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
